mem_port_arbiter: RTL

- Arbitrates the single 64-bit, 8-byte-wide synchronous RAM between two requesters:
  - the instruction-fetch port (IF, read-only);
  - the load/store port (LS, read/write, driven by the mem stage with byte enables and replicated write data).
- Grants at most one access per cycle and drives the RAM port.
- Routes the 1-cycle-latency read data back to the requester that issued the access.
- Prevents IF starvation under back-to-back LS traffic.

---
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single-ported 64-bit data RAM.
// The load/store port normally wins; after MAX_LS_STREAK consecutive LS grants
// with fetch waiting, fetch is given the next slot. The RAM has a 1-cycle read
// latency, so the owner of each access is remembered to route the response.
module mem_port_arbiter #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  // Instruction-fetch port (read-only)
  input  logic              if_req_i,
  input  logic [XLEN-1:0]   if_addr_i,
  input  logic              if_kill_i,
  output logic              if_gnt_o,
  output logic              if_rsp_valid_o,
  output logic [XLEN-1:0]   if_rdata_o,

  // Load/store port
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [XLEN-1:0]   ls_addr_i,
  input  logic [XLEN/8-1:0] ls_byte_en_i,
  input  logic [XLEN-1:0]   ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rsp_valid_o,
  output logic [XLEN-1:0]   ls_rdata_o,

  // RAM port
  output logic [XLEN-1:0]   ram_addr_o,
  output logic              ram_ren_o,
  output logic              ram_wen_o,
  output logic [XLEN/8-1:0] ram_byte_en_o,
  output logic [XLEN-1:0]   ram_wdata_o,
  input  logic [XLEN-1:0]   ram_rdata_i
);

  localparam int unsigned BeW       = XLEN / 8;
  localparam logic [3:0]  MaxStreak = 4'(MAX_LS_STREAK);

  logic       r_rsp_pend;
  logic       r_rsp_owner_ls;
  logic       r_rsp_we;
  logic [3:0] r_streak;

  logic       w_if_eff;
  logic       w_if_win;
  logic       w_ls_win;
  logic       w_rsp_ls;
  logic       w_rsp_if;

  // Grant decision: LS priority, fetch forced through once the streak saturates.
  // Grants are suppressed while reset is asserted.
  always_comb begin
    w_if_eff = if_req_i & ~if_kill_i;
    w_ls_win = rst_n & ls_req_i & ~(w_if_eff & (r_streak == MaxStreak));
    w_if_win = rst_n & w_if_eff & ~w_ls_win;
    if_gnt_o = w_if_win;
    ls_gnt_o = w_ls_win;
  end

  // Drive the RAM from whichever port won this cycle; idle port is all zeros.
  always_comb begin
    ram_addr_o    = '0;
    ram_ren_o     = 1'b0;
    ram_wen_o     = 1'b0;
    ram_byte_en_o = '0;
    ram_wdata_o   = '0;
    if (w_ls_win) begin
      ram_addr_o = {ls_addr_i[XLEN-1:3], 3'b000};
      if (ls_we_i) begin
        ram_wen_o     = 1'b1;
        ram_byte_en_o = ls_byte_en_i;
        ram_wdata_o   = ls_wdata_i;
      end else begin
        ram_ren_o = 1'b1;
      end
    end else if (w_if_win) begin
      ram_addr_o = {if_addr_i[XLEN-1:3], 3'b000};
      ram_ren_o  = 1'b1;
    end
  end

  // Track the in-flight access and the LS streak; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_pend     <= 1'b0;
      r_rsp_owner_ls <= 1'b0;
      r_rsp_we       <= 1'b0;
      r_streak       <= 4'd0;
    end else begin
      r_rsp_pend     <= w_if_win | w_ls_win;
      r_rsp_owner_ls <= w_ls_win;
      r_rsp_we       <= w_ls_win & ls_we_i;
      if (w_ls_win && w_if_eff) begin
        // Saturate so the counter never wraps back below the threshold.
        if (r_streak != MaxStreak) begin
          r_streak <= r_streak + 4'd1;
        end
      end else begin
        r_streak <= 4'd0;
      end
    end
  end

  // Route the RAM read data to the owner; a fetch redirect squashes its response.
  always_comb begin
    w_rsp_ls       = rst_n & r_rsp_pend & r_rsp_owner_ls;
    w_rsp_if       = rst_n & r_rsp_pend & ~r_rsp_owner_ls & ~if_kill_i;
    ls_rsp_valid_o = w_rsp_ls;
    if_rsp_valid_o = w_rsp_if;
    ls_rdata_o     = '0;
    if_rdata_o     = '0;
    if (w_rsp_ls && !r_rsp_we) begin
      ls_rdata_o = ram_rdata_i;
    end
    if (w_rsp_if) begin
      if_rdata_o = ram_rdata_i;
    end
  end

  logic [BeW-1:0] w_unused_be;
  assign w_unused_be = '0;

endmodule
